// File: rtl/cov_pkg.sv
// Shared types and constants for the covariance feed controller.
// Contents:
//   N_ASSETS    - assets per snapshot
//   q8_8_t      - signed Q8.8 price / statistic word
//   vec_t       - one value per asset, element [0] is asset 0
//   mat_t       - N_ASSETS x N_ASSETS matrix of q8_8_t
//   fsm_t       - controller states
//   sat_inc     - saturating sample-count increment
package cov_pkg;

  localparam int N_ASSETS = 4;

  typedef logic signed [15:0] q8_8_t;
  typedef q8_8_t [0:N_ASSETS-1] vec_t;
  typedef vec_t [0:N_ASSETS-1] mat_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    COMMIT  = 2'd3
  } fsm_t;

  // The sample count only ever counts up, so it is treated as unsigned here
  // and clamps at the ceiling instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] t, input logic [15:0] t_max);
    logic [15:0] r;
    if (t >= t_max) r = t_max;
    else            r = t + 16'd1;
    return r;
  endfunction

endpackage

// File: rtl/snapshot_collector.sv
// Gathers per-asset price ticks into complete snapshots.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   tick_valid   - tick strobe
//   tick_asset   - asset index of the tick
//   tick_price   - Q8.8 price of the tick
//   take         - consumer drops the pending snapshot this cycle
//   pending      - a complete snapshot is waiting to be consumed
//   pending_p    - the waiting snapshot
module snapshot_collector
  import cov_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_valid,
  input  logic [1:0] tick_asset,
  input  q8_8_t      tick_price,
  input  logic       take,
  output logic       pending,
  output vec_t       pending_p
);

  vec_t                stage;
  vec_t                stage_next;
  logic [N_ASSETS-1:0] mask;
  logic [N_ASSETS-1:0] mask_next;
  logic                complete;

  // Fold this cycle's tick into the staging view first, so a tick that fills
  // the last slot belongs to the snapshot it completes. Duplicate ticks simply
  // overwrite the staged value.
  always_comb begin
    stage_next = stage;
    mask_next  = mask;
    if (tick_valid) begin
      stage_next[tick_asset] = tick_price;
      mask_next[tick_asset]  = 1'b1;
    end
    complete = &mask_next;
  end

  // A new completion always overwrites the pending slot, even if the consumer
  // is taking the old one in the same cycle, so the latest snapshot wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage     <= '0;
      mask      <= '0;
      pending   <= 1'b0;
      pending_p <= '0;
    end else if (complete) begin
      stage     <= '0;
      mask      <= '0;
      pending   <= 1'b1;
      pending_p <= stage_next;
    end else begin
      stage <= stage_next;
      mask  <= mask_next;
      if (take) pending <= 1'b0;
    end
  end

endmodule

// File: rtl/cov_feed_ctrl.sv
// Sequencer in front of update_cov: turns completed price snapshots into
// update transactions and commits the returned moment/mean/covariance.
// Ports:
//   clk_100mhz, reset_n          - clock, asynchronous active-low reset
//   tick_valid/asset/price       - incoming price ticks
//   old_p, new_p                 - previous / current snapshot to update_cov
//   old_moment, old_mean, T      - stored state presented with the launch
//   valid                        - one-cycle launch pulse
//   ready, overflow              - update_cov result strobe and overflow flag
//   new_moment, new_mean, new_cov- update_cov results
//   cov_out, cov_out_valid       - last committed covariance and commit pulse
//   err_overflow, err_timeout    - sticky error flags
module cov_feed_ctrl
  import cov_pkg::*;
#(
  parameter logic [15:0] T_MAX   = 16'd256,
  parameter logic [15:0] TIMEOUT = 16'd64
) (
  input  logic       clk_100mhz,
  input  logic       reset_n,
  input  logic       tick_valid,
  input  logic [1:0] tick_asset,
  input  q8_8_t      tick_price,
  output vec_t       old_p,
  output vec_t       new_p,
  output mat_t       old_moment,
  output vec_t       old_mean,
  output q8_8_t      T,
  output logic       valid,
  input  logic       ready,
  input  logic       overflow,
  input  mat_t       new_moment,
  input  vec_t       new_mean,
  input  mat_t       new_cov,
  output mat_t       cov_out,
  output logic       cov_out_valid,
  output logic       err_overflow,
  output logic       err_timeout
);

  fsm_t        state;
  logic        primed;
  logic [15:0] wait_cnt;
  logic        pending;
  vec_t        pending_p;
  logic        take;
  mat_t        cap_moment;
  vec_t        cap_mean;
  mat_t        cap_cov;
  logic        cap_ovf;

  // The pending snapshot is only consumed while idle; in the other states it
  // sits in the collector (and may be replaced) until the FSM returns.
  assign take = (state == COLLECT) && pending;

  snapshot_collector u_collector (
    .clk        (clk_100mhz),
    .rst_n      (reset_n),
    .tick_valid (tick_valid),
    .tick_asset (tick_asset),
    .tick_price (tick_price),
    .take       (take),
    .pending    (pending),
    .pending_p  (pending_p)
  );

  assign valid         = (state == LAUNCH);
  assign cov_out_valid = (state == COMMIT) && !cap_ovf;

  // The very first snapshot only primes old_p; every later one launches an
  // update. Results are captured in WAIT and applied one cycle later in
  // COMMIT, so the launch-side outputs never change while update_cov works.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state        <= COLLECT;
      primed       <= 1'b0;
      wait_cnt     <= '0;
      old_p        <= '0;
      new_p        <= '0;
      old_moment   <= '0;
      old_mean     <= '0;
      T            <= '0;
      cov_out      <= '0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
      cap_moment   <= '0;
      cap_mean     <= '0;
      cap_cov      <= '0;
      cap_ovf      <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (pending) begin
            if (!primed) begin
              old_p  <= pending_p;
              primed <= 1'b1;
              T      <= 16'sd1;
            end else begin
              new_p <= pending_p;
              state <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (ready) begin
            cap_moment <= new_moment;
            cap_mean   <= new_mean;
            cap_cov    <= new_cov;
            cap_ovf    <= overflow;
            state      <= COMMIT;
          end else if (wait_cnt == TIMEOUT - 16'd1) begin
            err_timeout <= 1'b1;
            old_p       <= new_p;
            state       <= COLLECT;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        COMMIT: begin
          if (!cap_ovf) begin
            old_moment <= cap_moment;
            old_mean   <= cap_mean;
            cov_out    <= cap_cov;
            T          <= sat_inc(T, T_MAX);
          end else begin
            err_overflow <= 1'b1;
          end
          old_p <= new_p;
          state <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_cov_feed_ctrl.sv
// Directed bench for cov_feed_ctrl with a behavioural update_cov stub.
module tb_cov_feed_ctrl;
  import cov_pkg::*;

  logic       clk_100mhz;
  logic       reset_n;
  logic       tick_valid;
  logic [1:0] tick_asset;
  q8_8_t      tick_price;
  vec_t       old_p;
  vec_t       new_p;
  mat_t       old_moment;
  vec_t       old_mean;
  q8_8_t      T;
  logic       valid;
  logic       ready;
  logic       overflow;
  mat_t       new_moment;
  vec_t       new_mean;
  mat_t       new_cov;
  mat_t       cov_out;
  logic       cov_out_valid;
  logic       err_overflow;
  logic       err_timeout;

  int errors = 0;
  int checks = 0;

  // Stub controls
  int   stub_delay    = 3;
  bit   stub_overflow = 1'b0;
  bit   stub_never    = 1'b0;
  mat_t stub_moment;
  vec_t stub_mean;
  mat_t stub_cov;

  // Monitor state
  int   valid_count     = 0;
  int   cov_valid_count = 0;
  vec_t last_new_p;

  cov_feed_ctrl dut (
    .clk_100mhz    (clk_100mhz),
    .reset_n       (reset_n),
    .tick_valid    (tick_valid),
    .tick_asset    (tick_asset),
    .tick_price    (tick_price),
    .old_p         (old_p),
    .new_p         (new_p),
    .old_moment    (old_moment),
    .old_mean      (old_mean),
    .T             (T),
    .valid         (valid),
    .ready         (ready),
    .overflow      (overflow),
    .new_moment    (new_moment),
    .new_mean      (new_mean),
    .new_cov       (new_cov),
    .cov_out       (cov_out),
    .cov_out_valid (cov_out_valid),
    .err_overflow  (err_overflow),
    .err_timeout   (err_timeout)
  );

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_100mhz);
  endtask

  // One tick for one cycle; called and returns on a falling edge.
  task automatic applyStimulus(input logic [1:0] asset, input logic [15:0] price);
    tick_valid = 1'b1;
    tick_asset = asset;
    tick_price = price;
    @(negedge clk_100mhz);
    tick_valid = 1'b0;
  endtask

  task automatic sendSnapshot(input vec_t v);
    for (int i = 0; i < N_ASSETS; i++) applyStimulus(i[1:0], v[i]);
  endtask

  function automatic vec_t mkVec(input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] c, input logic [15:0] d);
    vec_t v;
    v = {a, b, c, d};
    return v;
  endfunction

  // update_cov stub: answers each launch after stub_delay cycles
  initial begin
    ready      = 1'b0;
    overflow   = 1'b0;
    new_moment = '0;
    new_mean   = '0;
    new_cov    = '0;
    forever begin
      @(negedge clk_100mhz);
      if (valid && !stub_never) begin
        repeat (stub_delay) @(negedge clk_100mhz);
        ready      = 1'b1;
        overflow   = stub_overflow;
        new_moment = stub_moment;
        new_mean   = stub_mean;
        new_cov    = stub_cov;
        @(negedge clk_100mhz);
        ready    = 1'b0;
        overflow = 1'b0;
      end
    end
  end

  always @(negedge clk_100mhz) begin
    if (valid) begin
      valid_count++;
      last_new_p = new_p;
    end
    if (cov_out_valid) cov_valid_count++;
  end

  initial begin
    vec_t s1, s2, s3, s4, s5, sa, sb, sc, sr;
    mat_t moment_a;
    int   vc0, cc0;

    for (int i = 0; i < N_ASSETS; i++)
      for (int j = 0; j < N_ASSETS; j++) begin
        stub_moment[i][j] = 16'h0100 + 16'(i * 16 + j);
        stub_cov[i][j]    = 16'h0A00 + 16'(i * 16 + j);
      end
    stub_mean  = mkVec(16'd1, 16'd2, 16'd3, 16'd4);
    last_new_p = '0;
    moment_a   = stub_moment;

    s1 = mkVec(16'h0040, 16'h00D0, 16'hFEBC, 16'h006C);
    s2 = mkVec(16'h006F, 16'h0043, 16'hFF02, 16'h00A7);
    s3 = mkVec(16'h0010, 16'h0020, 16'h0030, 16'h0040);
    s4 = mkVec(16'h0111, 16'h0122, 16'h0133, 16'h0144);
    s5 = mkVec(16'h0005, 16'h0006, 16'h0007, 16'h0008);
    sa = mkVec(16'h0011, 16'h0022, 16'h0200, 16'h0033);
    sb = mkVec(16'h0B00, 16'h0B01, 16'h0B02, 16'h0B03);
    sc = mkVec(16'h0C00, 16'h0C01, 16'h0C02, 16'h0C03);
    sr = mkVec(16'h0777, 16'h0888, 16'h0999, 16'h0AAA);

    // Reset state
    reset_n    = 1'b0;
    tick_valid = 1'b0;
    tick_asset = '0;
    tick_price = '0;
    waitCycles(3);
    checkOutput("reset_valid", {255'd0, valid}, 256'd0);
    checkOutput("reset_T", T, 256'd0);
    checkOutput("reset_old_p", old_p, 256'd0);
    checkOutput("reset_errs", {254'd0, err_overflow, err_timeout}, 256'd0);
    reset_n = 1'b1;
    waitCycles(1);

    // Priming snapshot: no launch, old_p loaded, T=1
    sendSnapshot(s1);
    waitCycles(3);
    checkOutput("prime_old_p", old_p, s1);
    checkOutput("prime_T", T, 256'd1);
    checkOutput("prime_no_valid", valid_count, 256'd0);

    // First real update, launch latency and commit
    sendSnapshot(s2);
    checkOutput("launch_not_early", {255'd0, valid}, 256'd0);
    waitCycles(1);
    checkOutput("launch_valid", {255'd0, valid}, 256'd1);
    checkOutput("launch_new_p", new_p, s2);
    checkOutput("launch_T", T, 256'd1);
    checkOutput("launch_old_p", old_p, s1);
    waitCycles(1);
    checkOutput("launch_one_cycle", {255'd0, valid}, 256'd0);
    waitCycles(10);
    checkOutput("commit_mean", old_mean, mkVec(16'd1, 16'd2, 16'd3, 16'd4));
    checkOutput("commit_moment", old_moment, moment_a);
    checkOutput("commit_cov", cov_out, stub_cov);
    checkOutput("commit_pulses", cov_valid_count, 256'd1);
    checkOutput("commit_T", T, 256'd2);
    checkOutput("commit_old_p", old_p, s2);

    // Overflow: state unchanged, sticky flag, no pulse
    stub_overflow = 1'b1;
    stub_mean     = mkVec(16'd9, 16'd9, 16'd9, 16'd9);
    for (int i = 0; i < N_ASSETS; i++)
      for (int j = 0; j < N_ASSETS; j++) stub_moment[i][j] = 16'h7777;
    sendSnapshot(s3);
    waitCycles(12);
    checkOutput("ovf_flag", {255'd0, err_overflow}, 256'd1);
    checkOutput("ovf_mean_kept", old_mean, mkVec(16'd1, 16'd2, 16'd3, 16'd4));
    checkOutput("ovf_moment_kept", old_moment, moment_a);
    checkOutput("ovf_T_kept", T, 256'd2);
    checkOutput("ovf_no_pulse", cov_valid_count, 256'd1);
    checkOutput("ovf_old_p", old_p, s3);

    // Timeout after 64 WAIT cycles
    stub_overflow = 1'b0;
    stub_never    = 1'b1;
    sendSnapshot(s4);
    waitCycles(65);
    checkOutput("timeout_not_early", {255'd0, err_timeout}, 256'd0);
    waitCycles(1);
    checkOutput("timeout_flag", {255'd0, err_timeout}, 256'd1);
    checkOutput("timeout_old_p", old_p, s4);
    checkOutput("timeout_T_kept", T, 256'd2);
    stub_never = 1'b0;
    stub_mean  = mkVec(16'd5, 16'd6, 16'd7, 16'd8);
    vc0 = valid_count;
    sendSnapshot(s5);
    waitCycles(15);
    checkOutput("after_to_launch", valid_count - vc0, 256'd1);
    checkOutput("after_to_T", T, 256'd3);
    checkOutput("after_to_mean", old_mean, mkVec(16'd5, 16'd6, 16'd7, 16'd8));
    checkOutput("ovf_sticky", {255'd0, err_overflow}, 256'd1);

    // Duplicate tick overwrites; two completions during WAIT -> latest wins
    stub_delay = 20;
    vc0 = valid_count;
    applyStimulus(2'd2, 16'h0100);
    applyStimulus(2'd2, 16'h0200);
    applyStimulus(2'd0, 16'h0011);
    applyStimulus(2'd1, 16'h0022);
    applyStimulus(2'd3, 16'h0033);
    waitCycles(2);
    checkOutput("dup_new_p", last_new_p, sa);
    sendSnapshot(sb);
    sendSnapshot(sc);
    waitCycles(60);
    checkOutput("latest_launches", valid_count - vc0, 256'd2);
    checkOutput("latest_new_p", last_new_p, sc);
    checkOutput("latest_old_p", old_p, sc);
    checkOutput("latest_T", T, 256'd5);

    // Saturation of T
    stub_delay = 1;
    cc0 = cov_valid_count;
    for (int i = 0; i < 300; i++) begin
      sendSnapshot(mkVec(16'(i), 16'(i + 1), 16'(i + 2), 16'(i + 3)));
      waitCycles(8);
      if (i == 249) checkOutput("T_before_sat", T, 256'd255);
    end
    checkOutput("T_saturated", T, 256'd256);
    checkOutput("sat_pulses", cov_valid_count - cc0, 256'd300);

    // Reset during WAIT; late ready ignored
    stub_delay = 10;
    sendSnapshot(sr);
    waitCycles(3);
    vc0 = valid_count;
    cc0 = cov_valid_count;
    reset_n = 1'b0;
    waitCycles(1);
    checkOutput("rst_valid", {255'd0, valid}, 256'd0);
    checkOutput("rst_T", T, 256'd0);
    checkOutput("rst_vectors", {old_p, new_p, old_mean, 64'd0}, 256'd0);
    checkOutput("rst_moment", old_moment, 256'd0);
    checkOutput("rst_cov", cov_out, 256'd0);
    checkOutput("rst_errs", {254'd0, err_overflow, err_timeout}, 256'd0);
    waitCycles(1);
    reset_n = 1'b1;
    waitCycles(15);
    checkOutput("late_ready_no_pulse", cov_valid_count - cc0, 256'd0);
    checkOutput("late_ready_no_launch", valid_count - vc0, 256'd0);
    checkOutput("late_ready_cov", cov_out, 256'd0);
    checkOutput("late_ready_T", T, 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
